calc_keypad_tx: RTL and testbench

- Command transmitter for calc_top: scans a 4x4 key matrix, debounces presses and encodes each press into the 4-bit cmd code.
- Presents each command to the calculator as a fixed-length hold, then returns cmd to the no-op code.
- Waits for the calculator's status to leave BUSY before sending, so no command is dropped.
- Sits between board keypad pins and calc_top.cmd.

---
 rtl/calc_pkg.sv | 78 +++++++
 rtl/calc_debounce.sv | 34 +++
 rtl/calc_keypad_tx.sv | 127 ++++++++++++
 tb/tb_calc_keypad_tx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad transmitter: command codes, status,
// scanner states and the key-matrix lookup.
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_ADD  = 4'b1010,
    CMD_SUB  = 4'b1011,
    CMD_MUL  = 4'b1100,
    CMD_CLR  = 4'b1101,
    CMD_EQ   = 4'b1110,
    CMD_IDLE = 4'b1111
  } cmd_t;

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_ERROR = 2'b10
  } status_t;

  typedef enum logic [2:0] {
    K_SCAN,
    K_DEBOUNCE,
    K_WAIT_READY,
    K_SEND,
    K_WAIT_RELEASE
  } kstate_t;

  typedef struct packed {
    logic       reserved;
    logic [3:0] code;
  } key_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Digits carry their binary value; r3c3 has no command.
  function automatic key_t key_lookup(input logic [1:0] r, input logic [1:0] c);
    key_t k;
    k.reserved = 1'b0;
    k.code     = CMD_IDLE;
    case ({r, c})
      4'h0: k.code = 4'b0001;
      4'h1: k.code = 4'b0010;
      4'h2: k.code = 4'b0011;
      4'h3: k.code = CMD_ADD;
      4'h4: k.code = 4'b0100;
      4'h5: k.code = 4'b0101;
      4'h6: k.code = 4'b0110;
      4'h7: k.code = CMD_SUB;
      4'h8: k.code = 4'b0111;
      4'h9: k.code = 4'b1000;
      4'hA: k.code = 4'b1001;
      4'hB: k.code = CMD_MUL;
      4'hC: k.code = CMD_CLR;
      4'hD: k.code = 4'b0000;
      4'hE: k.code = CMD_EQ;
      default: k.reserved = 1'b1;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/calc_debounce.sv
// Stable-for-N counter: done pulses on the target-th consecutive match,
// fail flags any mismatch while enabled.
module calc_debounce #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en_i,
  input  logic         match_i,
  input  logic [W-1:0] target_i,
  output logic         done_o,
  output logic         fail_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign done_o  = en_i && match_i && (cnt_inc >= {1'b0, target_i});
  assign fail_o  = en_i && !match_i;

  // Restarting on done lets the next phase begin from zero without a gap.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || !match_i || done_o) cnt_d = '0;
    else                             cnt_d = cnt_inc[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (srst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/calc_keypad_tx.sv
// 4x4 keypad scanner that debounces a press, waits for the calculator to be
// non-busy and then holds the encoded command on cmd for a fixed time.
module calc_keypad_tx
  import calc_pkg::*;
#(
  parameter int SCAN_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic [1:0] status,
  output logic [3:0] cmd,
  output logic       cmd_active,
  output logic [7:0] sent_count
);

  localparam int CNT_W = cnt_width(max3(SCAN_CYCLES, DEBOUNCE_CYCLES, HOLD_CYCLES));

  kstate_t          state_q;
  logic [3:0]       col_q;
  logic [3:0]       row_q;
  logic [1:0]       row_idx_q;
  logic [1:0]       col_idx_q;
  logic [CNT_W-1:0] scan_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [3:0]       cmd_q;
  logic             active_q;
  logic [7:0]       sent_q;

  key_t             key_sel;
  logic             db_en, db_match, db_done, db_fail;
  logic [CNT_W-1:0] db_target;

  assign key_sel = key_lookup(row_idx_q, col_idx_q);

  // The scan sample that found the key is the first stable sample, so the
  // press phase needs one fewer match than the release phase.
  assign db_en     = (state_q == K_DEBOUNCE) || (state_q == K_WAIT_RELEASE);
  assign db_match  = (state_q == K_DEBOUNCE) ? (row_in == row_q) : ((row_in & row_q) == 4'b0000);
  assign db_target = (state_q == K_DEBOUNCE) ? CNT_W'(DEBOUNCE_CYCLES - 1) : CNT_W'(DEBOUNCE_CYCLES);

  calc_debounce #(.W(CNT_W)) u_debounce (
    .clk      (clock),
    .srst     (reset),
    .en_i     (db_en),
    .match_i  (db_match),
    .target_i (db_target),
    .done_o   (db_done),
    .fail_o   (db_fail)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= K_SCAN;
      col_q      <= 4'b0001;
      row_q      <= '0;
      row_idx_q  <= '0;
      col_idx_q  <= '0;
      scan_cnt_q <= '0;
      hold_cnt_q <= '0;
      cmd_q      <= CMD_IDLE;
      active_q   <= 1'b0;
      sent_q     <= '0;
    end else begin
      unique case (state_q)
        K_SCAN: begin
          if (scan_cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_q <= '0;
            if ($onehot(row_in)) begin
              row_q     <= row_in;
              row_idx_q <= onehot_idx(row_in);
              col_idx_q <= onehot_idx(col_q);
              state_q   <= K_DEBOUNCE;
            end else begin
              col_q <= {col_q[2:0], col_q[3]};
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        K_DEBOUNCE: begin
          if (db_fail) begin
            col_q   <= {col_q[2:0], col_q[3]};
            state_q <= K_SCAN;
          end else if (db_done) begin
            state_q <= key_sel.reserved ? K_WAIT_RELEASE : K_WAIT_READY;
          end
        end
        K_WAIT_READY: begin
          if (status != ST_BUSY) begin
            cmd_q      <= key_sel.code;
            active_q   <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= K_SEND;
          end
        end
        K_SEND: begin
          if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cmd_q    <= CMD_IDLE;
            active_q <= 1'b0;
            sent_q   <= sent_q + 8'd1;
            state_q  <= K_WAIT_RELEASE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        K_WAIT_RELEASE: begin
          if (db_done) begin
            col_q      <= 4'b0001;
            scan_cnt_q <= '0;
            state_q    <= K_SCAN;
          end
        end
        default: state_q <= K_SCAN;
      endcase
    end
  end

  assign col_out    = col_q;
  assign cmd        = cmd_q;
  assign cmd_active = active_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_calc_keypad_tx.sv
// Randomised scoreboard bench for calc_keypad_tx: a key-matrix model drives
// row_in, expected codes are queued per press and a monitor checks each send.
module tb_calc_keypad_tx;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [1:0] status = 2'b00;
  logic [3:0] cmd;
  logic       cmd_active;
  logic [7:0] sent_count;

  logic [3:0] keys [4];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q [$];
  logic [7:0] model_sent = 8'd0;
  int         done_cnt = 0;
  int         code_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 13, 0, 14, -1};

  logic       prev_active = 1'b0;
  logic [1:0] prev_status = 2'b00;
  logic [3:0] cur_exp = 4'hF;
  int         hold_len = 0;

  calc_keypad_tx dut (
    .clock      (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .status     (status),
    .cmd        (cmd),
    .cmd_active (cmd_active),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  // A pressed key connects its column drive to its row.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = |(keys[r] & col_out);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ready_status();
    int s;
    s = $urandom_range(0, 2);
    return (s == 0) ? 2'b00 : ((s == 1) ? 2'b10 : 2'b11);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      prev_active = 1'b0;
      prev_status = 2'b00;
      hold_len    = 0;
    end else begin
      if (cmd_active && !prev_active) begin
        check("start_not_busy", 32'(prev_status == 2'b01), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd: got %0h expected none", cmd);
          cur_exp = cmd;
        end else begin
          cur_exp = exp_q.pop_front();
          check("cmd_code", 32'(cmd), 32'(cur_exp));
        end
        hold_len = 1;
      end else if (cmd_active) begin
        hold_len++;
        check("cmd_stable", 32'(cmd), 32'(cur_exp));
      end else begin
        check("idle_code", 32'(cmd), 32'(4'hF));
        if (prev_active) begin
          check("hold_len", 32'(hold_len), 32'(HOLD));
          model_sent = model_sent + 8'd1;
          check("sent_count_inc", 32'(sent_count), 32'(model_sent));
          done_cnt++;
        end
      end
      prev_active = cmd_active;
      prev_status = status;
    end
  end

  task automatic press(input int r, input int c, input int busy, input int extra);
    int code, target, t, hold_more;
    code      = code_tbl[r*4+c];
    target    = done_cnt + ((code >= 0) ? 1 : 0);
    hold_more = (code >= 0) ? extra : extra + 30;
    if (code >= 0) exp_q.push_back(4'(code));
    status = (busy > 0) ? 2'b01 : ready_status();
    keys[r][c] = 1'b1;
    if (busy > 0) begin
      repeat (busy) step();
      check("busy_hold", 32'(cmd_active), 32'(0));
      status = ready_status();
      step();
      if (code >= 0) check("ready_latency", 32'(cmd_active), 32'(1));
    end
    t = 0;
    while (done_cnt < target && t < 400) begin
      step();
      t++;
    end
    check("press_done", 32'(done_cnt >= target), 32'(1));
    repeat (hold_more) step();
    keys[r][c] = 1'b0;
    repeat (DEB + 6) step();
    check("sent_after", 32'(sent_count), 32'(model_sent));
    $display("press r%0d c%0d busy=%0d code=%0d sent=%0d", r, c, busy, code, sent_count);
  endtask

  initial begin
    int t, r, c, busy;
    logic [3:0] seen;
    for (int i = 0; i < 4; i++) keys[i] = 4'b0000;

    repeat (3) step();
    check("rst_col", 32'(col_out), 32'(4'b0001));
    check("rst_cmd", 32'(cmd), 32'(4'hF));
    check("rst_active", 32'(cmd_active), 32'(0));
    check("rst_sent", 32'(sent_count), 32'(0));
    reset = 1'b0;
    step();

    press(0, 1, 0, 30);
    check("long_hold_sent", 32'(sent_count), 32'(1));
    press(1, 3, 30, 5);

    // Bounce on r3c2, aligned to the start of column 2's dwell.
    t = 0;
    while (col_out == 4'b0100 && t < 50) begin step(); t++; end
    t = 0;
    while (col_out != 4'b0100 && t < 50) begin step(); t++; end
    check("bounce_sync", 32'(col_out), 32'(4'b0100));
    exp_q.push_back(4'hE);
    t = done_cnt + 1;
    keys[3][2] = 1'b1;
    repeat (2) step();
    keys[3][2] = 1'b0;
    step();
    keys[3][2] = 1'b1;
    r = 0;
    while (done_cnt < t && r < 400) begin step(); r++; end
    check("bounce_done", 32'(done_cnt >= t), 32'(1));
    keys[3][2] = 1'b0;
    repeat (DEB + 6) step();
    $display("bounce r3c2 sent=%0d", sent_count);

    // Ghost press: two rows in one column must never be latched.
    keys[0][0] = 1'b1;
    keys[2][0] = 1'b1;
    seen = 4'b0000;
    repeat (40) begin
      step();
      seen = seen | col_out;
    end
    check("ghost_rotate", 32'(seen), 32'(4'hF));
    check("ghost_no_cmd", 32'(cmd_active), 32'(0));
    keys[0][0] = 1'b0;
    keys[2][0] = 1'b0;
    repeat (10) step();
    check("ghost_sent", 32'(sent_count), 32'(model_sent));
    $display("ghost r0+r2 c0 cols_seen=%b", seen);

    // Reserved key: column freezes while held, scan restarts at column 0.
    keys[3][3] = 1'b1;
    repeat (30) step();
    check("rsv_frozen_a", 32'(col_out), 32'(4'b1000));
    repeat (5) step();
    check("rsv_frozen_b", 32'(col_out), 32'(4'b1000));
    keys[3][3] = 1'b0;
    repeat (DEB) step();
    check("rsv_resume", 32'(col_out), 32'(4'b0001));
    repeat (10) step();
    check("rsv_sent", 32'(sent_count), 32'(model_sent));
    $display("reserved r3c3 sent=%0d", sent_count);

    for (int n = 0; n < 10; n++) begin
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      busy = (code_tbl[r*4+c] >= 0 && $urandom_range(0, 2) == 0) ? $urandom_range(30, 40) : 0;
      press(r, c, busy, $urandom_range(0, 30));
    end

    // Reset in the middle of sending digit 5.
    status = 2'b00;
    exp_q.push_back(4'b0101);
    keys[1][1] = 1'b1;
    t = 0;
    while (!cmd_active && t < 100) begin step(); t++; end
    check("rst_mid_started", 32'(cmd_active), 32'(1));
    repeat (3) step();
    reset = 1'b1;
    keys[1][1] = 1'b0;
    step();
    check("rst_mid_cmd", 32'(cmd), 32'(4'hF));
    check("rst_mid_active", 32'(cmd_active), 32'(0));
    check("rst_mid_col", 32'(col_out), 32'(4'b0001));
    check("rst_mid_sent", 32'(sent_count), 32'(0));
    reset = 1'b0;
    exp_q.delete();
    model_sent = 8'd0;
    $display("reset mid-send cmd=%0h sent=%0d", cmd, sent_count);
    step();

    press(0, 0, 0, 5);
    press(0, 3, 0, 5);
    press(0, 1, 0, 5);
    press(3, 2, 0, 5);
    check("seq_sent", 32'(sent_count), 32'(4));
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
